// File: rtl/fp64_mant_mul_seq_pkg.sv
// Shared FP64 significand-multiplier definitions: widths, FSM state
// encoding and significand/product types.
package fp64_mant_mul_seq_pkg;

  localparam int unsigned FP64_MANT_W = 53;
  localparam int unsigned FP64_PROD_W = 2 * FP64_MANT_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [FP64_MANT_W-1:0] fp64_mant_t;
  typedef logic [FP64_PROD_W-1:0] fp64_prod_t;

endpackage

// File: rtl/fp64_mant_mul_seq_mant_add_step.sv
// One shift-and-add step: conditionally adds the multiplicand to the low
// accumulator bits, returning a (MANT_W+1)-bit sum that keeps the carry.
module fp64_mant_mul_seq_mant_add_step #(
  parameter int unsigned MANT_W = 53
) (
  input  logic [MANT_W-1:0] acc_lo,
  input  logic [MANT_W-1:0] mcand,
  input  logic              mplier_lsb,
  output logic [MANT_W:0]   sum
);

  logic [MANT_W:0] addend;

  // Gate the multiplicand by the current multiplier bit and add with carry-out.
  always_comb begin
    addend = '0;
    if (mplier_lsb) addend = {1'b0, mcand};
    sum = {1'b0, acc_lo} + addend;
  end

endmodule

// File: rtl/fp64_mant_mul_seq.sv
// Iterative radix-2 shift-and-add multiplier for FP64 significands.
// Produces the full unnormalised 2*MANT_W-bit product after MANT_W
// add-shift iterations.
// Optional feature: define EARLY_TERM_EN to finish as soon as all
// unconsumed multiplier bits are zero (one-shot barrel shift to DONE).
module fp64_mant_mul_seq
  import fp64_mant_mul_seq_pkg::*;
#(
  parameter int unsigned MANT_W = FP64_MANT_W,
  parameter int unsigned CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MANT_W-1:0]     a_mant,
  input  logic [MANT_W-1:0]     b_mant,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2*MANT_W-1:0]   product,
  output logic                  busy
);

  state_e             state_q, state_d;
  logic [MANT_W-1:0]  mcand_q, mcand_d;
  // Accumulator holds only the low MANT_W bits: after each right shift the
  // (MANT_W+1)-bit accumulator's top bit is always zero.
  logic [MANT_W-1:0]  acc_q, acc_d;
  logic [MANT_W-1:0]  mplier_q, mplier_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [MANT_W:0]    s;

  fp64_mant_mul_seq_mant_add_step #(
    .MANT_W (MANT_W)
  ) u_mant_add_step (
    .acc_lo     (acc_q),
    .mcand      (mcand_q),
    .mplier_lsb (mplier_q[0]),
    .sum        (s)
  );

`ifdef EARLY_TERM_EN
  logic [MANT_W-1:0]  unconsumed;
  logic [CNT_W:0]     shamt;

  // Multiplier bits not yet consumed, and the shift that skips them all.
  always_comb begin
    unconsumed = mplier_q & ({MANT_W{1'b1}} >> cnt_q);
    shamt      = (CNT_W+1)'(MANT_W) - {1'b0, cnt_q};
  end
`endif

  // Next-state logic for the FSM, datapath registers and registered outputs.
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        // Acceptance is gated by the registered ready so nothing is taken
        // in the first cycle after reset release.
        if (in_valid && in_ready_q) begin
          mcand_d  = a_mant;
          acc_d    = '0;
          mplier_d = b_mant;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
`ifdef EARLY_TERM_EN
        if (unconsumed == '0) begin
          {acc_d, mplier_d} = {acc_q, mplier_q} >> shamt;
          state_d           = DONE;
        end else
`endif
        begin
          acc_d    = s[MANT_W:1];
          mplier_d = {s[0], mplier_q[MANT_W-1:1]};
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(MANT_W - 1)) state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == BUSY);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign product   = {acc_q, mplier_q};

endmodule

// File: tb/tb_fp64_mant_mul_seq.sv
// Directed and light random checks for fp64_mant_mul_seq.
module tb_fp64_mant_mul_seq;

  localparam int unsigned MW = 53;
  localparam int unsigned PW = 2 * MW;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [MW-1:0] a_mant;
  logic [MW-1:0] b_mant;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] product;
  logic          busy;

  int unsigned tests_run;
  int unsigned tests_failed;

  fp64_mant_mul_seq #(
    .MANT_W (MW),
    .CNT_W  (6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_mant    (a_mant),
    .b_mant    (b_mant),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Edges from the accept edge (counted as 1) to the edge raising out_valid.
  function automatic int unsigned exp_lat(input logic [MW-1:0] b);
`ifdef EARLY_TERM_EN
    int hb;
    hb = -1;
    for (int i = 0; i < int'(MW); i++) if (b[i]) hb = i;
    return (hb + 3 > 54) ? 54 : int'(hb + 3);
`else
    return (b === b) ? 54 : 0;
`endif
  endfunction

  task automatic do_op(input string tag, input logic [MW-1:0] a, input logic [MW-1:0] b,
                       input logic [PW-1:0] exp_p, input int unsigned stall,
                       input logic hold_valid);
    int unsigned n;
    int unsigned lat;
    logic [PW-1:0] held;
    in_valid = 1'b1;
    a_mant   = a;
    b_mant   = b;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check({tag, "_ready_timeout"}, 128'(in_ready), 128'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    lat = 1;
    if (hold_valid) begin
      a_mant = ~a;
      b_mant = ~b;
    end else begin
      in_valid = 1'b0;
    end
    check({tag, "_busy"}, 128'({busy, in_ready}), 128'b10);
    while (!out_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    check({tag, "_lat"}, 128'(lat), 128'(exp_lat(b)));
    check({tag, "_prod"}, 128'(product), 128'(exp_p));
    held = product;
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clk);
      check({tag, "_stall"}, 128'({out_valid, in_ready, product}), 128'({1'b1, 1'b0, held}));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_post"}, 128'({out_valid, in_ready}), 128'b01);
  endtask

  logic [PW-1:0] e;
  logic [127:0]  rm;
  logic [MW-1:0] ra, rb;
  logic          seen;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a_mant    = '0;
    b_mant    = '0;
    repeat (3) @(negedge clk);
    check("rst_vals", 128'({in_ready, out_valid, busy, product}), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", 128'(in_ready), 128'd1);

    // 1.0 x 1.0
    do_op("one_one", 53'h10_0000_0000_0000, 53'h10_0000_0000_0000, 106'd1 << 104, 0, 1'b0);

    // all-ones squared: 2^106 - 2^54 + 1
    e = 106'd0 - (106'd1 << 54) + 106'd1;
    do_op("max_sq", 53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF, e, 0, 1'b0);

    // (2^53-1)(2^52+1) = 2^105 + 2^52 - 1, in_valid held through BUSY
    e = (106'd1 << 105) + (106'd1 << 52) - 106'd1;
    do_op("hold_valid", 53'h1F_FFFF_FFFF_FFFF, 53'h10_0000_0000_0001, e, 0, 1'b1);

    // 1.5 x 1.25 = 15 * 2^101, consumer stalls 10 cycles
    do_op("stall", 53'h18_0000_0000_0000, 53'h14_0000_0000_0000, 106'd15 << 101, 10, 1'b0);

    // reset in the middle of BUSY
    in_valid = 1'b1;
    a_mant   = 53'h1F_FFFF_FFFF_FFFF;
    b_mant   = 53'h1F_FFFF_FFFF_FFFF;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_busy", 128'(busy), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst", 128'({in_ready, out_valid, busy}), 128'd0);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_release", 128'({in_ready, out_valid, busy}), 128'b100);
    seen = 1'b0;
    repeat (60) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("mid_rst_no_valid", 128'(seen), 128'd0);
    do_op("after_rst", 53'd3, 53'd5, 106'd15, 0, 1'b0);

    // corners and random operands against a wide reference multiply
    for (int k = 0; k < 160; k++) begin
      ra = MW'({$urandom, $urandom});
      rb = MW'({$urandom, $urandom});
      case (k % 8)
        0: ra = '0;
        1: rb = '0;
        2: ra = MW'(1) << $urandom_range(52, 0);
        3: rb = MW'(1) << $urandom_range(52, 0);
        4: begin ra = '1; rb = MW'(1); end
        5: rb = MW'($urandom_range(255, 1));
        default: ;
      endcase
      rm = {75'd0, ra} * {75'd0, rb};
      do_op("rand", ra, rb, rm[PW-1:0], $urandom_range(3, 0), 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
